// File: rtl/paddle_game_ctrl.sv
// Game-flow controller for the paddle game: button edge detection, move-tick
// divider and the IDLE/SERVE/PLAY/PAUSED/OVER sequencer that owns lives.
module paddle_game_ctrl #(
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned LIVES       = 3,
   parameter int unsigned SERVE_TICKS = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       ball_missed,
   output logic       start,
   output logic       pause,
   output logic       move_left,
   output logic       move_right,
   output logic       tick,
   output logic [2:0] lives,
   output logic [2:0] game_state,
   output logic       game_over
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);
   localparam int unsigned SRV_W = $clog2(SERVE_TICKS + 1);
   localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SERVE  = 3'd1,
      S_PLAY   = 3'd2,
      S_PAUSED = 3'd3,
      S_OVER   = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [SRV_W-1:0]   srv_q, srv_d;
   logic [2:0]         lives_q, lives_d;
   logic               btn_start_q, btn_pause_q;
   logic               start_q, start_d;
   logic               pause_q, pause_d;
   logic               move_left_q, move_left_d;
   logic               move_right_q, move_right_d;
   logic               tick_q;
   logic               game_over_q, game_over_d;
   logic               tick_now, start_edge, pause_edge;

   assign tick_now   = (div_q == DIV_W'(TICK_DIV - 1));
   assign div_d      = tick_now ? '0 : div_q + DIV_W'(1);
   assign start_edge = btn_start & ~btn_start_q;
   assign pause_edge = btn_pause & ~btn_pause_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         srv_q        <= '0;
         lives_q      <= LIVES_INIT;
         btn_start_q  <= 1'b0;
         btn_pause_q  <= 1'b0;
         start_q      <= 1'b0;
         pause_q      <= 1'b1;
         move_left_q  <= 1'b0;
         move_right_q <= 1'b0;
         tick_q       <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         srv_q        <= srv_d;
         lives_q      <= lives_d;
         btn_start_q  <= btn_start;
         btn_pause_q  <= btn_pause;
         start_q      <= start_d;
         pause_q      <= pause_d;
         move_left_q  <= move_left_d;
         move_right_q <= move_right_d;
         tick_q       <= tick_now;
         game_over_q  <= game_over_d;
      end
   end

   // Next state; registered outputs are derived from the state being entered.
   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      srv_d        = srv_q;
      start_d      = 1'b0;
      move_left_d  = 1'b0;
      move_right_d = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_edge) begin
               state_d = S_SERVE;
               lives_d = LIVES_INIT;
               start_d = 1'b1;
            end
         end
         S_SERVE: begin
            if (tick_now) begin
               if (srv_q == SRV_W'(SERVE_TICKS - 1)) state_d = S_PLAY;
               else                                  srv_d   = srv_q + SRV_W'(1);
            end
         end
         S_PLAY: begin
            if (ball_missed) begin
               if (lives_q <= 3'd1) begin
                  state_d = S_OVER;
                  lives_d = 3'd0;
               end else begin
                  state_d = S_SERVE;
                  lives_d = lives_q - 3'd1;
                  start_d = 1'b1;
               end
            end else if (pause_edge) begin
               state_d = S_PAUSED;
            end else begin
               move_left_d  = tick_now & btn_left & ~btn_right;
               move_right_d = tick_now & btn_right & ~btn_left;
            end
         end
         S_PAUSED: begin
            if (start_edge) begin
               state_d = S_SERVE;
               lives_d = LIVES_INIT;
               start_d = 1'b1;
            end else if (pause_edge) begin
               state_d = S_PLAY;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_SERVE && state_q != S_SERVE) srv_d = '0;
      pause_d     = (state_d != S_PLAY);
      game_over_d = (state_d == S_OVER);
   end

   assign start      = start_q;
   assign pause      = pause_q;
   assign move_left  = move_left_q;
   assign move_right = move_right_q;
   assign tick       = tick_q;
   assign lives      = lives_q;
   assign game_state = state_q;
   assign game_over  = game_over_q;

endmodule

// File: tb/tb_paddle_game_ctrl.sv
// Directed bench for paddle_game_ctrl with TICK_DIV=4, LIVES=3, SERVE_TICKS=2:
// a cycle-by-cycle vector table from reset, then hand-written corner sequences.
module tb_paddle_game_ctrl;

   localparam int unsigned TICK_DIV    = 4;
   localparam int unsigned LIVES       = 3;
   localparam int unsigned SERVE_TICKS = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_start = 1'b0, btn_pause = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       ball_missed = 1'b0;
   logic       start, pause, move_left, move_right, tick, game_over;
   logic [2:0] lives, game_state;

   int checks = 0;
   int failures = 0;

   paddle_game_ctrl #(
      .TICK_DIV(TICK_DIV), .LIVES(LIVES), .SERVE_TICKS(SERVE_TICKS)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_start(btn_start), .btn_pause(btn_pause), .btn_left(btn_left),
      .btn_right(btn_right), .ball_missed(ball_missed),
      .start(start), .pause(pause), .move_left(move_left), .move_right(move_right),
      .tick(tick), .lives(lives), .game_state(game_state), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // {game_state, start, pause, lives, move_left, move_right, tick, game_over}
   logic [11:0] obs;
   assign obs = {game_state, start, pause, lives, move_left, move_right, tick, game_over};

   typedef struct packed {
      logic [4:0]  in;    // {start, pause, left, right, missed}
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [4:0] in, input logic [2:0] gs, input logic s,
                               input logic p, input logic [2:0] lv, input logic ml,
                               input logic mr, input logic tk, input logic go);
      vec_t v;
      v.in  = in;
      v.exp = {gs, s, p, lv, ml, mr, tk, go};
      return v;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Apply inputs away from the edge, then sample 1 time unit after the edge.
   task automatic step(input logic [4:0] in);
      {btn_start, btn_pause, btn_left, btn_right, ball_missed} = in;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_play(input string name);
      int n = 0;
      while (game_state != 3'd2 && n < 20) begin
         step(5'b00000);
         n++;
      end
      chk(name, int'(game_state), 2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt_l, cnt_r, bad;

      // Edge n after release corresponds to table entry n-1; tick after edges 4,8,12...
      tbl.push_back(mk(5'b00000, 3'd0, 0, 1, 3'd3, 0, 0, 0, 0)); // n1
      tbl.push_back(mk(5'b10000, 3'd1, 1, 1, 3'd3, 0, 0, 0, 0)); // n2 start edge
      tbl.push_back(mk(5'b10000, 3'd1, 0, 1, 3'd3, 0, 0, 0, 0)); // n3 held
      tbl.push_back(mk(5'b00000, 3'd1, 0, 1, 3'd3, 0, 0, 1, 0)); // n4
      tbl.push_back(mk(5'b01001, 3'd1, 0, 1, 3'd3, 0, 0, 0, 0)); // n5 pause/miss ignored
      tbl.push_back(mk(5'b00000, 3'd1, 0, 1, 3'd3, 0, 0, 0, 0)); // n6
      tbl.push_back(mk(5'b10000, 3'd1, 0, 1, 3'd3, 0, 0, 0, 0)); // n7 start ignored
      tbl.push_back(mk(5'b00000, 3'd2, 0, 0, 3'd3, 0, 0, 1, 0)); // n8 -> PLAY
      tbl.push_back(mk(5'b00100, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0)); // n9
      tbl.push_back(mk(5'b00100, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00100, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00100, 3'd2, 0, 0, 3'd3, 1, 0, 1, 0)); // n12 move left
      tbl.push_back(mk(5'b00110, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00110, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00110, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00110, 3'd2, 0, 0, 3'd3, 0, 0, 1, 0)); // n16 both: none
      tbl.push_back(mk(5'b00010, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00010, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00010, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00010, 3'd2, 0, 0, 3'd3, 0, 1, 1, 0)); // n20 move right
      tbl.push_back(mk(5'b01000, 3'd3, 0, 1, 3'd3, 0, 0, 0, 0)); // n21 -> PAUSED
      tbl.push_back(mk(5'b01100, 3'd3, 0, 1, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b01100, 3'd3, 0, 1, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b01101, 3'd3, 0, 1, 3'd3, 0, 0, 1, 0)); // n24 miss ignored
      tbl.push_back(mk(5'b00000, 3'd3, 0, 1, 3'd3, 0, 0, 0, 0));
      tbl.push_back(mk(5'b01000, 3'd2, 0, 0, 3'd3, 0, 0, 0, 0)); // n26 -> PLAY
      tbl.push_back(mk(5'b00001, 3'd1, 1, 1, 3'd2, 0, 0, 0, 0)); // n27 miss -> SERVE
      tbl.push_back(mk(5'b00000, 3'd1, 0, 1, 3'd2, 0, 0, 1, 0));
      tbl.push_back(mk(5'b00000, 3'd1, 0, 1, 3'd2, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 3'd1, 0, 1, 3'd2, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 3'd1, 0, 1, 3'd2, 0, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 3'd2, 0, 0, 3'd2, 0, 0, 1, 0)); // n32 -> PLAY

      repeat (3) @(negedge clk);
      chk("reset_values", int'(obs), int'({3'd0, 1'b0, 1'b1, 3'd3, 4'b0000}));
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].in);
         chk($sformatf("vec%0d", i + 1), int'(obs), int'(tbl[i].exp));
      end

      // Miss and pause edge together: miss wins.
      step(5'b01001);
      chk("collision_state", int'(game_state), 1);
      chk("collision_lives", int'(lives), 1);
      chk("collision_start", int'(start), 1);
      wait_play("serve_to_play_1");

      // Last life lost.
      step(5'b00001);
      chk("over_state", int'(game_state), 4);
      chk("over_lives", int'(lives), 0);
      chk("over_flag", int'(game_over), 1);
      chk("over_pause", int'(pause), 1);
      step(5'b10000);
      chk("restart_state", int'(game_state), 1);
      chk("restart_lives", int'(lives), 3);
      chk("restart_start", int'(start), 1);
      chk("restart_over_clr", int'(game_over), 0);
      step(5'b10000);
      chk("start_single", int'(start), 0);
      wait_play("serve_to_play_2");

      // PLAY was entered on a tick edge, so 12 cycles hold exactly 3 ticks.
      cnt_l = 0; bad = 0;
      for (int i = 0; i < 12; i++) begin
         step(5'b00100);
         cnt_l += int'(move_left);
         if (move_left && !tick) bad++;
      end
      chk("left_count", cnt_l, 3);
      chk("left_on_tick", bad, 0);
      cnt_l = 0; cnt_r = 0;
      for (int i = 0; i < 12; i++) begin
         step(5'b00110);
         cnt_l += int'(move_left);
         cnt_r += int'(move_right);
      end
      chk("both_no_move", cnt_l + cnt_r, 0);

      // Held pause: one entry into PAUSED, no movement.
      step(5'b01100);
      chk("pause_enter", int'(game_state), 3);
      bad = 0; cnt_l = 0;
      for (int i = 0; i < 19; i++) begin
         step(5'b01100);
         if (game_state != 3'd3 || !pause) bad++;
         cnt_l += int'(move_left);
      end
      chk("pause_held_stays", bad, 0);
      chk("pause_held_no_move", cnt_l, 0);
      step(5'b00000);
      step(5'b01000);
      chk("resume_state", int'(game_state), 2);
      chk("resume_pause", int'(pause), 0);

      // Start beats pause while PAUSED.
      step(5'b00000);
      step(5'b01000);
      chk("pause_again", int'(game_state), 3);
      step(5'b00000);
      step(5'b11000);
      chk("prio_state", int'(game_state), 1);
      chk("prio_start", int'(start), 1);
      wait_play("serve_to_play_3");

      // Asynchronous reset between edges while PAUSED.
      step(5'b01000);
      chk("pre_reset_state", int'(game_state), 3);
      #2 reset = 1'b0;
      #1 chk("async_reset", int'(obs), int'({3'd0, 1'b0, 1'b1, 3'd3, 4'b0000}));
      step(5'b00000);
      chk("reset_held", int'(game_state), 0);
      #3 reset = 1'b1;
      btn_pause = 1'b0;
      step(5'b00000);
      chk("post_reset_idle", int'(obs), int'({3'd0, 1'b0, 1'b1, 3'd3, 4'b0000}));
      step(5'b00000);
      step(5'b00000);
      step(5'b00000);
      chk("post_reset_tick", int'(tick), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
